// File: rtl/viking_pkg.sv
// Shared constants, FSM state type and word-reorder rule for the mono capture path.
package viking_pkg;

  localparam logic [22:0] BASE    = 23'h600000;
  localparam logic [22:0] BASE_HI = 23'h740000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VS,
    ST_CAPTURE,
    ST_DRAIN
  } cap_state_e;

  // Packer holds the first pixel at bit 63; RAM expects 16-bit groups in reverse order.
  function automatic logic [63:0] reorder_word(input logic [63:0] p);
    return {p[15:0], p[31:16], p[47:32], p[63:48]};
  endfunction

endpackage

// File: rtl/mono_capture_fifo.sv
// Show-ahead 64-bit FIFO between the pixel packer and the bus side.
module mono_capture_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic [63:0] din_i,
  output logic [63:0] dout_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [63:0]   mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rp_q];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= nxt(wp_q);
      end
      if (do_pop) rp_q <= nxt(rp_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mono_capture.sv
// Mono video capture: packs 1-bit pixels into 64-bit words and writes them to RAM in bus slot 3.
// Optional per-line pixel count check enabled by defining MONO_CAPTURE_LINECHK_EN.
module mono_capture
  import viking_pkg::*;
#(
  parameter int unsigned H          = 1280,
  parameter int unsigned V          = 1024,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        clk_8_en,
  input  logic [1:0]  bus_cycle,
  input  logic        himem,
  input  logic        enable,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic        pix_in,
  output logic [22:0] addr,
  output logic        write,
  output logic [63:0] data,
  output logic        overflow,
  output logic        frame_done
`ifdef MONO_CAPTURE_LINECHK_EN
  ,
  output logic        line_err
`endif
);

  localparam int unsigned LW = $clog2(V + 1);

  cap_state_e    state_q;
  logic          vs_q, de_q;
  logic [63:0]   pk_q, pk_d, pk_set;
  logic [5:0]    pcnt_q, pcnt_d;
  logic [LW-1:0] line_q;
  logic [22:0]   addr_q;
  logic          ovf_q, done_q;

  logic          cap, take, de_fall, vs_rise, vs_fall;
  logic          push, push_full, push_part, pop;
  logic          f_full, f_empty;
  logic [63:0]   push_word;

  always_comb begin
    cap     = (state_q == ST_CAPTURE);
    de_fall = de_q && !de_in;
    vs_rise = !vs_q && vs_in;
    vs_fall = vs_q && !vs_in;
    take    = cap && de_in;

    pk_set                  = pk_q;
    pk_set[6'd63 - pcnt_q]  = !pix_in;

    push_full = take && (pcnt_q == 6'd63);
    push_part = cap && de_fall && (pcnt_q != '0);
    push      = push_full || push_part;
    // Unwritten packer bits are already zero, so a partial word is zero-padded as-is.
    push_word = reorder_word(push_full ? pk_set : pk_q);

    pk_d   = pk_q;
    pcnt_d = pcnt_q;
    if (!cap || push) begin
      pk_d   = '0;
      pcnt_d = '0;
    end else if (take) begin
      pk_d   = pk_set;
      pcnt_d = pcnt_q + 6'd1;
    end
  end

  assign write      = (bus_cycle == 2'd3) && !f_empty;
  assign pop        = write && clk_8_en;
  assign addr       = addr_q;
  assign overflow   = ovf_q;
  assign frame_done = done_q;

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      vs_q    <= 1'b0;
      de_q    <= 1'b0;
      pk_q    <= '0;
      pcnt_q  <= '0;
      line_q  <= '0;
      addr_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      vs_q   <= vs_in;
      de_q   <= de_in;
      pk_q   <= pk_d;
      pcnt_q <= pcnt_d;
      done_q <= 1'b0;

      if (pop) addr_q <= addr_q + 23'd4;

      if (!enable) ovf_q <= 1'b0;
      else if (push && f_full && !pop) ovf_q <= 1'b1;

      case (state_q)
        ST_IDLE: if (enable) state_q <= ST_WAIT_VS;
        ST_WAIT_VS: begin
          if (vs_rise) begin
            state_q <= ST_CAPTURE;
            line_q  <= '0;
            addr_q  <= himem ? BASE_HI : BASE;
          end
        end
        ST_CAPTURE: begin
          if (de_fall) line_q <= line_q + 1'b1;
          if ((de_fall && (line_q == LW'(V - 1))) || vs_fall) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (f_empty) begin
            state_q <= ST_IDLE;
            done_q  <= (line_q == LW'(V));
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  mono_capture_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (pclk),
    .rst_ni (reset_n),
    .push_i (push),
    .pop_i  (pop),
    .din_i  (push_word),
    .dout_o (data),
    .full_o (f_full),
    .empty_o(f_empty)
  );

`ifdef MONO_CAPTURE_LINECHK_EN
  localparam int unsigned XW = $clog2(H + 2);

  logic [XW-1:0] xcnt_q;
  logic          lerr_q;

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      xcnt_q <= '0;
      lerr_q <= 1'b0;
    end else begin
      if (!cap || de_fall) xcnt_q <= '0;
      else if (take && (xcnt_q != XW'(H + 1))) xcnt_q <= xcnt_q + 1'b1;

      if (!enable) lerr_q <= 1'b0;
      else if (cap && de_fall && (xcnt_q != XW'(H))) lerr_q <= 1'b1;
    end
  end

  assign line_err = lerr_q;
`endif

endmodule

// File: tb/tb_mono_capture.sv
// Self-checking bench for mono_capture (small H/V so whole frames fit in a short run).
module tb_mono_capture;

  localparam int H = 96;
  localparam int V = 3;

  logic        pclk = 1'b0;
  logic        reset_n, clk_8_en, himem, enable, vs_in, de_in, pix_in;
  logic [1:0]  bus_cycle;
  logic [22:0] addr;
  logic        write;
  logic [63:0] data;
  logic        overflow, frame_done;
`ifdef MONO_CAPTURE_LINECHK_EN
  logic        line_err;
`endif

  mono_capture #(
    .H(H),
    .V(V),
    .FIFO_DEPTH(4)
  ) dut (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .clk_8_en  (clk_8_en),
    .bus_cycle (bus_cycle),
    .himem     (himem),
    .enable    (enable),
    .vs_in     (vs_in),
    .de_in     (de_in),
    .pix_in    (pix_in),
    .addr      (addr),
    .write     (write),
    .data      (data),
    .overflow  (overflow),
    .frame_done(frame_done)
`ifdef MONO_CAPTURE_LINECHK_EN
    ,
    .line_err  (line_err)
`endif
  );

  always #5 pclk = ~pclk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int bus_mode = 2;  // 0: slot rotation, 1: slot stuck at 0, 2: random
  int done_cnt = 0;

  logic [63:0] got_d[$];
  logic [22:0] got_a[$];
  logic [63:0] exp_q[$];

  // Record every accepted RAM write as seen just before the committing edge.
  always @(negedge pclk) begin
    if (reset_n && write && clk_8_en && bus_cycle == 2'd3) begin
      got_d.push_back(data);
      got_a.push_back(addr);
    end
    if (reset_n && frame_done) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
    cyc++;
    case (bus_mode)
      0: begin
        bus_cycle = 2'((cyc / 16) % 4);
        clk_8_en  = (cyc % 16 == 15);
      end
      1: begin
        bus_cycle = 2'd0;
        clk_8_en  = (cyc % 16 == 15);
      end
      default: begin
        bus_cycle = 2'($urandom_range(3));
        clk_8_en  = 1'($urandom_range(1));
      end
    endcase
  endtask

  // Reference: pixel i of a line lands in word i/64; within the stored word, its 16-pixel
  // group keeps its index but the pixel order inside the group runs from bit 15 down.
  task automatic model_line(input bit px[$]);
    logic [63:0] w;
    w = '0;
    foreach (px[i]) begin
      int k;
      k = i % 64;
      if (!px[i]) w[16 * (k / 16) + 15 - (k % 16)] = 1'b1;
      if (k == 63 || i == px.size() - 1) begin
        exp_q.push_back(w);
        w = '0;
      end
    end
  endtask

  task automatic drive_line(input bit px[$], input int gap, input int fuse_at);
    foreach (px[i]) begin
      tick();
      de_in  = 1'b1;
      pix_in = px[i];
      if (i == fuse_at) begin
        bus_cycle = 2'd3;
        clk_8_en  = 1'b1;
      end
    end
    tick();
    de_in  = 1'b0;
    pix_in = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic frame_start(input logic hm);
    himem = hm;
    vs_in = 1'b0;
    repeat (4) tick();
    vs_in = 1'b1;
    repeat (3) tick();
  endtask

  task automatic wait_words(input int n);
    int t;
    t = 0;
    while (got_d.size() < n && t < 3000) begin
      tick();
      t++;
    end
    if (got_d.size() < n) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d words required %0d", got_d.size(), n);
    end
    repeat (6) tick();
  endtask

  task automatic clear_logs();
    got_d.delete();
    got_a.delete();
    exp_q.delete();
    done_cnt = 0;
  endtask

  // kind 0: random pixels, 1: all white. hm_sel 2 picks himem at random.
  task automatic run_frame(input int idx, input int kind, input int bmode,
                           input int short_line, input int hm_sel);
    logic        hm;
    logic [22:0] base;
    hm   = (hm_sel == 2) ? 1'($urandom_range(1)) : 1'(hm_sel);
    base = hm ? 23'h740000 : 23'h600000;
    clear_logs();
    bus_mode = bmode;
    frame_start(hm);
    for (int l = 0; l < V; l++) begin
      bit px[$];
      int n;
      n = (l == short_line) ? H - 1 : H;
      for (int i = 0; i < n; i++) px.push_back((kind == 1) ? 1'b1 : 1'($urandom_range(1)));
      model_line(px);
      drive_line(px, (bmode == 0) ? 64 : 40, -1);
    end
    vs_in = 1'b0;
    wait_words(exp_q.size());
    chk($sformatf("frame%0d_count", idx), 64'(got_d.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_d.size(); k++) begin
      chk($sformatf("frame%0d_data%0d", idx, k), got_d[k], exp_q[k]);
      chk($sformatf("frame%0d_addr%0d", idx, k), 64'(got_a[k]), 64'(base + 23'(4 * k)));
    end
    chk($sformatf("frame%0d_end_addr", idx), 64'(addr), 64'(base + 23'(4 * exp_q.size())));
    chk($sformatf("frame%0d_done", idx), 64'(done_cnt), 64'd1);
    chk($sformatf("frame%0d_ovf", idx), 64'(overflow), 64'd0);
  endtask

  // Fill the FIFO with bus slot 3 withheld; optionally pop exactly as the 5th word is pushed.
  task automatic stuck_line(input bit fuse);
    bit px[$];
    clear_logs();
    bus_mode = 1;
    frame_start(1'b0);
    for (int i = 0; i < 320; i++) px.push_back(1'b0);
    drive_line(px, 4, fuse ? 319 : -1);
    chk(fuse ? "fuse_ovf" : "stuck_ovf", 64'(overflow), fuse ? 64'd0 : 64'd1);
    chk(fuse ? "fuse_write" : "stuck_write", 64'(write), 64'd0);
    if (!fuse) begin
      enable = 1'b0;
      tick();
      tick();
      chk("ovf_cleared", 64'(overflow), 64'd0);
      enable = 1'b1;
    end
    vs_in    = 1'b0;
    bus_mode = 2;
    wait_words(fuse ? 5 : 4);
    chk(fuse ? "fuse_count" : "stuck_count", 64'(got_d.size()), fuse ? 64'd5 : 64'd4);
    foreach (got_d[k]) chk($sformatf("stuck_data%0d", k), got_d[k], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("stuck_no_done", 64'(done_cnt), 64'd0);
  endtask

  typedef struct {
    logic        hm;
    int          len;
    int          nblack;
    int          nw;
    logic [63:0] w0;
    logic [63:0] w1;
  } vec_t;

  vec_t tbl[6];
  bit   lpx[$];

  initial begin
    tbl[0] = '{1'b0, 70, 70, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FC00};
    tbl[1] = '{1'b1, 64, 16, 1, 64'h0000_0000_0000_FFFF, 64'h0};
    tbl[2] = '{1'b0, 64, 0, 1, 64'h0000_0000_0000_0000, 64'h0};
    tbl[3] = '{1'b1, 20, 1, 1, 64'h0000_0000_0000_8000, 64'h0};
    tbl[4] = '{1'b0, 96, 80, 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_FFFF};
    tbl[5] = '{1'b0, 33, 33, 1, 64'h0000_8000_FFFF_FFFF, 64'h0};

    reset_n = 1'b0; enable = 1'b0; himem = 1'b0;
    vs_in = 1'b0; de_in = 1'b0; pix_in = 1'b0;
    bus_cycle = 2'd0; clk_8_en = 1'b0;

    repeat (3) tick();
    bus_cycle = 2'd3;
    clk_8_en  = 1'b1;
    #1;
    chk("reset_write", 64'(write), 64'd0);
    chk("reset_addr", 64'(addr), 64'd0);
    chk("reset_ovf", 64'(overflow), 64'd0);
    chk("reset_done", 64'(frame_done), 64'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    tick();

    // Single aborted lines: no frame_done, exact words and addresses.
    bus_mode = 2;
    foreach (tbl[v]) begin
      logic [22:0] base;
      base = tbl[v].hm ? 23'h740000 : 23'h600000;
      clear_logs();
      lpx.delete();
      for (int i = 0; i < tbl[v].len; i++) lpx.push_back(i >= tbl[v].nblack);
      frame_start(tbl[v].hm);
      drive_line(lpx, 8, -1);
      vs_in = 1'b0;
      wait_words(tbl[v].nw);
      chk($sformatf("vec%0d_count", v), 64'(got_d.size()), 64'(tbl[v].nw));
      if (got_d.size() > 0) begin
        chk($sformatf("vec%0d_w0", v), got_d[0], tbl[v].w0);
        chk($sformatf("vec%0d_a0", v), 64'(got_a[0]), 64'(base));
      end
      if (tbl[v].nw > 1 && got_d.size() > 1) begin
        chk($sformatf("vec%0d_w1", v), got_d[1], tbl[v].w1);
        chk($sformatf("vec%0d_a1", v), 64'(got_a[1]), 64'(base + 23'd4));
      end
      chk($sformatf("vec%0d_no_done", v), 64'(done_cnt), 64'd0);
    end

    // Full all-white frame on the rotating bus: V*2 zero words, one frame_done.
    run_frame(0, 1, 0, -1, 0);
    chk("white_writes", 64'(got_d.size()), 64'(V * ((H + 63) / 64)));
    chk("white_end_addr", 64'(addr), 64'(23'h600018));

    for (int f = 1; f <= 3; f++) run_frame(f, 0, 2, -1, 2);

    stuck_line(1'b1);
    stuck_line(1'b0);

    // Reset in the middle of a line with words buffered.
    clear_logs();
    bus_mode = 1;
    frame_start(1'b0);
    for (int i = 0; i < 130; i++) begin
      tick();
      de_in  = 1'b1;
      pix_in = 1'b0;
    end
    tick();
    bus_cycle = 2'd3;
    clk_8_en  = 1'b0;
    #1;
    chk("pre_rst_write", 64'(write), 64'd1);
    reset_n = 1'b0;
    tick();
    bus_cycle = 2'd3;
    clk_8_en  = 1'b1;
    #1;
    chk("rst_write", 64'(write), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    de_in   = 1'b0;
    vs_in   = 1'b0;
    got_d.delete();
    got_a.delete();
    bus_mode = 2;
    repeat (50) tick();
    chk("post_rst_nowrite", 64'(got_d.size()), 64'd0);

`ifdef MONO_CAPTURE_LINECHK_EN
    enable = 1'b0;
    tick();
    tick();
    chk("line_err_clear", 64'(line_err), 64'd0);
    enable = 1'b1;
    tick();
    run_frame(10, 0, 2, 1, 2);
    chk("line_err_set", 64'(line_err), 64'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
